// File: rtl/run_arbiter.sv
// Round-robin arbiter that hands a shared run unit to one of N_REQ requesters,
// drives the unit's run handshake, measures the busy duration and flags units that never start.
module run_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic [CNT_W-1:0] run_cycles,
  output logic             err_timeout,
  output logic             u_run_req,
  input  logic             u_run_busy,
  output logic             busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             ureq_q, ureq_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             sel_found;

  // Round-robin pick: first pending requester at or after last_grant+1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant_q) + 1 + k) % N_REQ);
      if (!sel_found && pending_q[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end else begin
        sel_idx = sel_idx;
      end
    end
  end

  // Next-state logic; pulse outputs fall back to 0 whenever ce is low.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    run_cycles_d = run_cycles_q;
    done_d       = '0;
    err_d        = 1'b0;
    ureq_d       = 1'b0;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            grant_d   = N_REQ'(1) << sel_idx;
            gidx_d    = sel_idx;
            pending_d = pending_q & ~(N_REQ'(1) << sel_idx);
            ureq_d    = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ISSUE: begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (u_run_busy) begin
            cnt_d   = CNT_W'(1);
            state_d = S_RUN;
          end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
            err_d        = 1'b1;
            done_d       = grant_q;
            run_cycles_d = '0;
            state_d      = S_DONE;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
        S_RUN: begin
          if (u_run_busy) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            run_cycles_d = cnt_q;
            done_d       = grant_q;
            state_d      = S_DONE;
          end
        end
        S_DONE: begin
          last_grant_d = gidx_q;
          grant_d      = '0;
          state_d      = S_IDLE;
        end
        default: begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      endcase
      // A request arriving in the grant cycle re-arms the bit just cleared.
      pending_d = pending_d | req;
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset taking priority over ce.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      cnt_q        <= '0;
      tcnt_q       <= '0;
      run_cycles_q <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      ureq_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      run_cycles_q <= run_cycles_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ureq_q       <= ureq_d;
      busy_q       <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign run_cycles  = run_cycles_q;
  assign err_timeout = err_q;
  assign u_run_req   = ureq_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_run_arbiter.sv
// Randomised and directed bench for run_arbiter, checked every cycle against a
// transaction-level model of the arbiter and an emulated shared unit.
module tb_run_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic             ce;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic [CNT_W-1:0] run_cycles;
  logic             err_timeout;
  logic             u_run_req;
  logic             u_run_busy;
  logic             busy;

  run_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .ce          (ce),
    .req         (req),
    .grant       (grant),
    .done        (done),
    .run_cycles  (run_cycles),
    .err_timeout (err_timeout),
    .u_run_req   (u_run_req),
    .u_run_busy  (u_run_busy),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // transaction-level model
  logic [N-1:0] m_pend;
  int           m_owner;
  int           m_last;
  bit           m_issued, m_seen, m_fin;
  int           m_waits, m_cnt, m_run;
  logic [N-1:0] e_done;
  logic         e_err, e_ureq;

  // emulated shared unit
  int unit_len = 5;
  int unit_rem = 0;
  bit unit_arm = 1'b0;

  // observation records
  logic [N-1:0] gseq[$];
  int nureq, ndone, nerr;
  int ureq_cyc, done_cyc, err_cyc, req_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic c, input logic b, input logic rs);
    int i;
    e_done = '0;
    e_err  = 1'b0;
    e_ureq = 1'b0;
    if (rs) begin
      m_pend = '0; m_owner = -1; m_last = N - 1; m_run = 0;
    end else if (c) begin
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          i = (m_last + 1 + k) % N;
          if (m_owner < 0 && ((m_pend >> i) & 1) != 0) m_owner = i;
        end
        if (m_owner >= 0) begin
          m_pend = m_pend & ~(N'(1) << m_owner);
          e_ureq = 1'b1;
          m_issued = 0; m_seen = 0; m_fin = 0; m_waits = 0; m_cnt = 0;
        end
      end else if (!m_issued) begin
        m_issued = 1;
      end else if (m_fin) begin
        m_last = m_owner; m_owner = -1;
      end else if (!m_seen) begin
        if (b) begin
          m_seen = 1; m_cnt = 1;
        end else begin
          m_waits++;
          if (m_waits == TIMEOUT) begin
            e_err = 1'b1; m_run = 0; m_fin = 1; e_done = N'(1) << m_owner;
          end
        end
      end else if (b) begin
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else begin
        m_run = m_cnt; m_fin = 1; e_done = N'(1) << m_owner;
      end
      m_pend = m_pend | r;
    end
  endtask

  // One clock: sample inputs, advance model, compare, record, then step the unit.
  task automatic tick();
    logic [N-1:0] r_s;
    logic c_s, b_s, rs_s;
    logic [N-1:0] e_grant;
    @(posedge clock);
    r_s = req; c_s = ce; b_s = u_run_busy; rs_s = reset;
    cyc++;
    model_step(r_s, c_s, b_s, rs_s);
    e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    #1;
    chk("grant", 32'(grant), 32'(e_grant));
    chk("done", 32'(done), 32'(e_done));
    chk("run_cycles", 32'(run_cycles), 32'(m_run));
    chk("err_timeout", 32'(err_timeout), 32'(e_err));
    chk("u_run_req", 32'(u_run_req), 32'(e_ureq));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    if (u_run_req) begin nureq++; ureq_cyc = cyc; gseq.push_back(grant); end
    if (done != '0) begin ndone++; done_cyc = cyc; end
    if (err_timeout) begin nerr++; err_cyc = cyc; end
    if (unit_rem > 0) unit_rem--;
    if (unit_arm) begin unit_rem = unit_len; unit_arm = 1'b0; end
    if (u_run_req && unit_len > 0) unit_arm = 1'b1;
    if (rs_s) begin unit_rem = 0; unit_arm = 1'b0; end
    u_run_busy = (unit_rem > 0);
  endtask

  task automatic clear_records();
    gseq.delete();
    nureq = 0; ndone = 0; nerr = 0;
    ureq_cyc = 0; done_cyc = 0; err_cyc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; req = '0;
    tick(); tick();
    reset = 1'b0;
    clear_records();
  endtask

  task automatic pulse_req(input logic [N-1:0] v);
    req = v; req_cyc = cyc;
    tick();
    req = '0;
  endtask

  task automatic run_quiet(input int budget);
    int n;
    n = 0;
    while ((m_owner >= 0 || m_pend != '0) && n < budget) begin tick(); n++; end
    checks++;
    if (m_owner >= 0 || m_pend != '0) begin
      errors++;
      $display("FAIL quiet_budget cyc=%0d actual=busy expected=idle within %0d", cyc, budget);
    end
    tick();
  endtask

  task automatic wait_ureq(input int budget);
    int n;
    n = 0;
    tick();
    while (!u_run_req && n < budget) begin tick(); n++; end
    chk("wait_ureq", 32'(u_run_req), 32'd1);
  endtask

  logic [N-1:0] exp2 [3] = '{4'b0001, 4'b0010, 4'b1000};
  logic [N-1:0] exp3 [3] = '{4'b0001, 4'b0100, 4'b0001};
  logic [N-1:0] held;

  initial begin
    reset = 1'b1; ce = 1'b1; req = '0; u_run_busy = 1'b0;
    m_pend = '0; m_owner = -1; m_last = N - 1; m_run = 0;
    m_issued = 0; m_seen = 0; m_fin = 0; m_waits = 0; m_cnt = 0;
    e_done = '0; e_err = 1'b0; e_ureq = 1'b0;
    do_reset();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_run_cycles", 32'(run_cycles), 32'd0);

    // single request, unit busy for 5 cycles
    unit_len = 5;
    pulse_req(4'b0001);
    run_quiet(60);
    chk("t1_nureq", 32'(nureq), 32'd1);
    chk("t1_ndone", 32'(ndone), 32'd1);
    chk("t1_grant", 32'(gseq.size() > 0 ? gseq[0] : 4'h0), 32'h1);
    chk("t1_run_cycles", 32'(run_cycles), 32'd5);
    chk("t1_model_run", 32'(m_run), 32'd5);
    chk("t1_latency", 32'(done_cyc - req_cyc), 32'd9);

    // counter saturates at all-ones
    do_reset();
    unit_len = 20;
    pulse_req(4'b0001);
    run_quiet(80);
    chk("sat_run_cycles", 32'(run_cycles), 32'(CMAX));

    // simultaneous requests served in round-robin order
    do_reset();
    unit_len = 3;
    pulse_req(4'b1011);
    run_quiet(100);
    chk("t2_count", 32'(gseq.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("t2_order", 32'(i < gseq.size() ? gseq[i] : 4'h0), 32'(exp2[i]));

    // fairness: req[0] re-pulsed while req[2] waits
    do_reset();
    unit_len = 4;
    pulse_req(4'b0101);
    for (int g = 0; g < 2; g++) begin
      wait_ureq(40);
      tick();
      pulse_req(4'b0001);
    end
    run_quiet(100);
    chk("t3_count", 32'(gseq.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("t3_order", 32'(i < gseq.size() ? gseq[i] : 4'h0), 32'(exp3[i]));

    // unit never goes busy
    do_reset();
    unit_len = 0;
    pulse_req(4'b0010);
    run_quiet(60);
    chk("t4_nerr", 32'(nerr), 32'd1);
    chk("t4_ndone", 32'(ndone), 32'd1);
    chk("t4_err_delay", 32'(err_cyc - ureq_cyc - 1), 32'd16);
    chk("t4_run_cycles", 32'(run_cycles), 32'd0);

    // ce stall inside RUN
    do_reset();
    unit_len = 8;
    pulse_req(4'b0001);
    wait_ureq(20);
    tick(); tick(); tick();
    held = grant;
    ce = 1'b0;
    tick(); tick(); tick();
    chk("t5_grant_frozen", 32'(grant), 32'(held));
    ce = 1'b1;
    run_quiet(60);
    chk("t5_run_cycles", 32'(run_cycles), 32'd5);

    // reset in the middle of a run
    do_reset();
    unit_len = 6;
    pulse_req(4'b0100);
    wait_ureq(20);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    tick(); tick(); tick();
    chk("t6_no_done", 32'(ndone), 32'd0);
    unit_len = 2;
    pulse_req(4'b1000);
    run_quiet(60);
    chk("t6_regrant", 32'(gseq.size() > 0 ? gseq[gseq.size()-1] : 4'h0), 32'h8);
    chk("t6_ndone", 32'(ndone), 32'd1);

    // randomised traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      ce = ($urandom_range(0, 7) != 0);
      req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      unit_len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; ce = 1'b1; req = '0; unit_len = 3;
    run_quiet(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/run_arbiter.md
RUN_ARBITER -- requirements
Module: run_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for the unit's busy to rise.
REQ-003 SHALL have parameter CNT_W, default 32: width of the run-cycle counter.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ce, input, 1 bit: clock enable; when 0, every register holds its value.
REQ-007 SHALL have port req, input, N_REQ bits: single-cycle run-request pulse per requester.
REQ-008 SHALL have port grant, output, N_REQ bits: one-hot owner of the shared unit, 0 when idle.
REQ-009 SHALL have port done, output, N_REQ bits: one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port run_cycles, output, CNT_W bits: busy-high duration of the last completed run.
REQ-011 SHALL have port err_timeout, output, 1 bit: one-cycle pulse when busy never rose.
REQ-012 SHALL have port u_run_req, output, 1 bit: run request to the shared unit.
REQ-013 SHALL have port u_run_busy, input, 1 bit: busy flag from the shared unit.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL sample req only when ce=1 and latch each asserted bit into pending[i].
REQ-016 SHALL clear pending[i] when requester i is granted; a req[i] in that same cycle SHALL leave pending[i] set (set wins).
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT_BUSY, RUN and DONE; all transitions occur only when ce=1.
REQ-018 IDLE: if pending is nonzero, SHALL select round-robin starting at index (last_grant+1) mod N_REQ, set grant, and go to ISSUE; after reset the search SHALL start at index 0.
REQ-019 ISSUE: SHALL drive u_run_req=1 for exactly one cycle, clear the cycle and timeout counters, and go to WAIT_BUSY.
REQ-020 WAIT_BUSY: if u_run_busy=1, SHALL go to RUN with the cycle counter set to 1.
REQ-021 WAIT_BUSY: otherwise SHALL increment the timeout counter and, on the TIMEOUT-th cycle without busy, pulse err_timeout and go to DONE.
REQ-022 RUN: while u_run_busy=1, SHALL increment the cycle counter, saturating at all-ones without wrapping.
REQ-023 RUN: when u_run_busy=0, SHALL go to DONE.
REQ-024 DONE: SHALL load run_cycles from the counter (0 after a timeout), pulse done[g] for one cycle, record last_grant=g, clear grant, and return to IDLE.
REQ-025 The minimum request-to-done latency SHALL be 4 cycles plus the number of busy-high cycles (IDLE→ISSUE→WAIT_BUSY→RUN→DONE).
REQ-026 grant SHALL remain stable and one-hot from ISSUE through DONE inclusive.
REQ-027 u_run_req SHALL never assert while u_run_busy is high outside WAIT_BUSY.
REQ-028 u_run_req SHALL never assert more than once per grant.
REQ-029 With ce=0, SHALL not drive pulse outputs (done, err_timeout, u_run_req) for more than the single cycle already registered.

Reset
REQ-030 On reset=1 at a clock edge, SHALL set state=IDLE and clear pending, grant, done, err_timeout, u_run_req and busy.
REQ-031 On the same reset, SHALL set run_cycles=0 and last_grant=N_REQ-1.
REQ-032 Reset SHALL take priority over ce.
REQ-033 Reset mid-run SHALL abort the transaction with no done pulse.

Verification
REQ-034 Single request: req=4'b0001 for one cycle, unit busy for 5 cycles -> one u_run_req pulse, grant=0001, done=0001 exactly once, run_cycles=5.
REQ-035 Simultaneous requests: req=4'b1011 in one cycle -> grants in order 0001, 0010, 1000, each done before the next u_run_req.
REQ-036 Fairness: req[0] re-pulsed during every run while req[2] stays pending -> grant alternates 0001, 0100, 0001.
REQ-037 Timeout: u_run_busy tied 0 -> err_timeout pulses 16 cycles after WAIT_BUSY entry, done pulses, run_cycles=0.
REQ-038 ce stall: ce=0 for 3 cycles during RUN -> all outputs frozen, run_cycles excludes the stalled cycles.
REQ-039 Reset mid-run: reset=1 during RUN -> next cycle busy=0, grant=0, no done; a subsequent req[3] is granted normally.
